seven_seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. Shares one BCD-to-segment decode path across NUM_DIGITS digits and drives one digit enable at a time, with dead-time between digits. Display data is loaded through a valid/ready handshake and is double-buffered so that updates take effect only at frame boundaries, which prevents tearing. Sits between the BCD counter datapath and the board's segment and anode pins.

---
 rtl/seven_seg_scan_ctrl_pkg.sv | 23 ++
 rtl/seven_seg_scan_ctrl_if.sv | 24 ++
 rtl/seven_seg_scan_ctrl_digit_dec.sv | 31 +++
 rtl/seven_seg_scan_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: active-low segment
// patterns ({g,f,e,d,c,b,a}) and the scan FSM state encoding.
package seven_seg_scan_ctrl_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_GAP  = 2'd2
   } scanState_t;

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Load port of the scan controller: valid/ready handshake plus the BCD word
// and its leading-zero blanking flag. With SEG7_SCAN_DP_EN defined the
// per-digit decimal-point bits travel with the load as well.
interface seven_seg_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      iLOAD_VALID;
   logic                      oLOAD_READY;
   logic [4*NUM_DIGITS-1:0]   iBCD;
   logic                      iBLANK_LZ;
`ifdef SEG7_SCAN_DP_EN
   logic [NUM_DIGITS-1:0]     iDP;

   modport master (output iLOAD_VALID, output iBCD, output iBLANK_LZ, output iDP,
                   input  oLOAD_READY);
   modport slave  (input  iLOAD_VALID, input  iBCD, input  iBLANK_LZ, input  iDP,
                   output oLOAD_READY);
`else
   modport master (output iLOAD_VALID, output iBCD, output iBLANK_LZ,
                   input  oLOAD_READY);
   modport slave  (input  iLOAD_VALID, input  iBCD, input  iBLANK_LZ,
                   output oLOAD_READY);
`endif
endinterface

// File: rtl/seven_seg_scan_ctrl_digit_dec.sv
// Combinational BCD-to-segment decoder. Codes 10..15 and a forced blank both
// produce a dark digit; all patterns are active-low {g,f,e,d,c,b,a}.
module seg7_digit_dec
   import seven_seg_scan_ctrl_pkg::*;
(
   input  logic [3:0] iCode,
   input  logic       iBlank,
   output logic [6:0] oSeg
);

   // Pattern lookup; blank wins over any code
   always_comb begin
      oSeg = SEG_BLANK;
      if (!iBlank) begin
         case (iCode)
            4'd0:    oSeg = SEG_0;
            4'd1:    oSeg = SEG_1;
            4'd2:    oSeg = SEG_2;
            4'd3:    oSeg = SEG_3;
            4'd4:    oSeg = SEG_4;
            4'd5:    oSeg = SEG_5;
            4'd6:    oSeg = SEG_6;
            4'd7:    oSeg = SEG_7;
            4'd8:    oSeg = SEG_8;
            4'd9:    oSeg = SEG_9;
            default: oSeg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// One digit is lit per slot (REFRESH_DIV cycles), followed by GAP_CYCLES of
// dead time. New values land in a pending buffer and are swapped into the
// active buffer only at frame boundaries, so a frame never mixes two values.
// Optional feature macro: SEG7_SCAN_DP_EN adds iDP (in the load interface)
// and the oDP_N decimal-point output.
module seven_seg_scan_ctrl
   import seven_seg_scan_ctrl_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int GAP_CYCLES  = 8,
   parameter int DIV_WIDTH   = 16
) (
   input  logic                  iCLK,
   input  logic                  iRST_N,
   seven_seg_scan_ctrl_if.slave  loadIf,
   output logic [6:0]            oSEG7,
   output logic [NUM_DIGITS-1:0] oDIG_EN_N,
`ifdef SEG7_SCAN_DP_EN
   output logic                  oDP_N,
`endif
   output logic                  oFRAME_DONE
);

   localparam int                   IDX_W        = $clog2(NUM_DIGITS);
   localparam logic [DIV_WIDTH-1:0] REFRESH_LAST = DIV_WIDTH'(REFRESH_DIV - 1);
   localparam logic [DIV_WIDTH-1:0] GAP_LAST     = DIV_WIDTH'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0]     IDX_LAST     = IDX_W'(NUM_DIGITS - 1);

   scanState_t              state, stateNxt;
   logic [IDX_W-1:0]        idx, idxNxt;
   logic [DIV_WIDTH-1:0]    div, divNxt;
   logic                    frameBoundary;

   logic [4*NUM_DIGITS-1:0] activeBcd, pendBcd;
   logic                    activeBlank, pendBlank;
   logic                    pendFull;
   logic                    accept;
`ifdef SEG7_SCAN_DP_EN
   logic [NUM_DIGITS-1:0]   activeDp, pendDp;
`endif

   logic [3:0]              curCode;
   logic                    lzBlank;
   logic [4*NUM_DIGITS-1:0] upperDigits;
   logic [6:0]              decSeg;

   assign loadIf.oLOAD_READY = !pendFull;
   assign accept             = loadIf.iLOAD_VALID && !pendFull;

   // Scan FSM state, digit index and slot divider
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state <= ST_IDLE;
         idx   <= '0;
         div   <= '0;
      end else begin
         state <= stateNxt;
         idx   <= idxNxt;
         div   <= divNxt;
      end
   end

   // Next-state logic: lit slot, dead-time gap, index advance and frame edge
   always_comb begin
      stateNxt      = state;
      idxNxt        = idx;
      divNxt        = div;
      frameBoundary = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               stateNxt = ST_SCAN;
               idxNxt   = '0;
               divNxt   = '0;
            end
         end
         ST_SCAN: begin
            if (div == REFRESH_LAST) begin
               stateNxt = ST_GAP;
               divNxt   = '0;
            end else begin
               divNxt = div + 1'b1;
            end
         end
         ST_GAP: begin
            if (div == GAP_LAST) begin
               stateNxt      = ST_SCAN;
               divNxt        = '0;
               frameBoundary = (idx == IDX_LAST);
               idxNxt        = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
               divNxt = div + 1'b1;
            end
         end
         default: begin
            stateNxt = ST_IDLE;
            idxNxt   = '0;
            divNxt   = '0;
         end
      endcase
   end

   // Double buffer: loads go to pending (or straight to active when idle);
   // pending is promoted only on a frame boundary
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         activeBcd   <= '0;
         activeBlank <= 1'b0;
         pendBcd     <= '0;
         pendBlank   <= 1'b0;
         pendFull    <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
         activeDp    <= '0;
         pendDp      <= '0;
`endif
      end else if (accept && (state == ST_IDLE)) begin
         activeBcd   <= loadIf.iBCD;
         activeBlank <= loadIf.iBLANK_LZ;
`ifdef SEG7_SCAN_DP_EN
         activeDp    <= loadIf.iDP;
`endif
      end else if (frameBoundary && pendFull) begin
         // accept cannot coincide here: ready is low while pending is full
         activeBcd   <= pendBcd;
         activeBlank <= pendBlank;
         pendFull    <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
         activeDp    <= pendDp;
`endif
      end else if (accept) begin
         pendBcd     <= loadIf.iBCD;
         pendBlank   <= loadIf.iBLANK_LZ;
         pendFull    <= 1'b1;
`ifdef SEG7_SCAN_DP_EN
         pendDp      <= loadIf.iDP;
`endif
      end
   end

   // Select the current digit and decide leading-zero blanking: a digit is
   // blanked when it and every more significant digit are zero (never digit 0)
   always_comb begin
      curCode     = activeBcd[4*int'(idx) +: 4];
      upperDigits = activeBcd >> (4 * int'(idx));
      lzBlank     = activeBlank && (idx != '0) && (upperDigits == '0);
   end

   seg7_digit_dec uDigitDec (
      .iCode  (curCode),
      .iBlank (lzBlank),
      .oSeg   (decSeg)
   );

   // Registered pin drivers; segments and anode change on the same edge
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         oSEG7       <= SEG_BLANK;
         oDIG_EN_N   <= '1;
         oFRAME_DONE <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
         oDP_N       <= 1'b1;
`endif
      end else begin
         oFRAME_DONE <= frameBoundary;
         if (state == ST_SCAN) begin
            oSEG7     <= decSeg;
            oDIG_EN_N <= ~(NUM_DIGITS'(1) << idx);
`ifdef SEG7_SCAN_DP_EN
            oDP_N     <= !activeDp[idx];
`endif
         end else begin
            oSEG7     <= SEG_BLANK;
            oDIG_EN_N <= '1;
`ifdef SEG7_SCAN_DP_EN
            oDP_N     <= 1'b1;
`endif
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl (NUM_DIGITS=4, REFRESH_DIV=4,
// GAP_CYCLES=1). The reference model tracks the number of clock edges since
// scanning started and derives the lit digit, gap and frame edge from it.
module tb_seven_seg_scan_ctrl;

   localparam int ND    = 4;
   localparam int RD    = 4;
   localparam int GC    = 1;
   localparam int SLOT  = RD + GC;
   localparam int FRAME = ND * SLOT;

   logic          iCLK = 1'b0;
   logic          iRST_N;
   logic [6:0]    oSEG7;
   logic [ND-1:0] oDIG_EN_N;
   logic          oFRAME_DONE;
`ifdef SEG7_SCAN_DP_EN
   logic          oDP_N;
`endif

   seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND)) loadIf ();

   seven_seg_scan_ctrl #(
      .NUM_DIGITS  (ND),
      .REFRESH_DIV (RD),
      .GAP_CYCLES  (GC),
      .DIV_WIDTH   (16)
   ) dut (
      .iCLK        (iCLK),
      .iRST_N      (iRST_N),
      .loadIf      (loadIf),
      .oSEG7       (oSEG7),
      .oDIG_EN_N   (oDIG_EN_N),
`ifdef SEG7_SCAN_DP_EN
      .oDP_N       (oDP_N),
`endif
      .oFRAME_DONE (oFRAME_DONE)
   );

   always #5 iCLK = ~iCLK;

   int checks = 0;
   int errors = 0;

   logic [6:0] segTab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

   // Reference model state
   bit          mRun;
   int          mK;
   logic [15:0] mAct, mPend;
   bit          mActBlank, mPendBlank, mPendFull, mAccepted;
   logic [6:0]  eSeg;
   logic [3:0]  eEn;
   logic        eFd;
`ifdef SEG7_SCAN_DP_EN
   logic [3:0]  mActDp, mPendDp;
   logic        eDp;
`endif

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [6:0] refSeg(input logic [15:0] v, input bit bl, input int d);
      logic [15:0] up;
      up = v >> (4 * d);
      if (d != 0 && bl && up == 16'h0) return 7'h7F;
      if (up[3:0] > 4'd9) return 7'h7F;
      return segTab[up[3:0]];
   endfunction

   function automatic void modelReset();
      mRun      = 1'b0;
      mK        = 0;
      mPendFull = 1'b0;
      mAccepted = 1'b0;
      eSeg      = 7'h7F;
      eEn       = 4'hF;
      eFd       = 1'b0;
`ifdef SEG7_SCAN_DP_EN
      eDp       = 1'b1;
`endif
   endfunction

   // Advance the model by one clock edge using the inputs present at the edge
   function automatic void modelEdge();
      bit acc;
      int s, d;
      bit lit;
      if (!iRST_N) begin
         modelReset();
         return;
      end
      acc       = loadIf.iLOAD_VALID && !mPendFull;
      mAccepted = acc;
      if (!mRun) begin
         eSeg = 7'h7F;
         eEn  = 4'hF;
         eFd  = 1'b0;
`ifdef SEG7_SCAN_DP_EN
         eDp  = 1'b1;
`endif
         if (acc) begin
            mRun      = 1'b1;
            mK        = 0;
            mAct      = loadIf.iBCD;
            mActBlank = loadIf.iBLANK_LZ;
`ifdef SEG7_SCAN_DP_EN
            mActDp    = loadIf.iDP;
`endif
         end
      end else begin
         mK++;
         s    = (mK - 1) % FRAME;
         d    = s / SLOT;
         lit  = (s % SLOT) < RD;
         eSeg = lit ? refSeg(mAct, mActBlank, d) : 7'h7F;
         eEn  = lit ? ~(4'b0001 << d) : 4'hF;
         eFd  = (mK % FRAME) == 0;
`ifdef SEG7_SCAN_DP_EN
         eDp  = lit ? !mActDp[d] : 1'b1;
`endif
         if (eFd && mPendFull) begin
            mAct      = mPend;
            mActBlank = mPendBlank;
            mPendFull = 1'b0;
`ifdef SEG7_SCAN_DP_EN
            mActDp    = mPendDp;
`endif
         end else if (acc) begin
            mPend      = loadIf.iBCD;
            mPendBlank = loadIf.iBLANK_LZ;
            mPendFull  = 1'b1;
`ifdef SEG7_SCAN_DP_EN
            mPendDp    = loadIf.iDP;
`endif
         end
      end
   endfunction

   task automatic checkAll();
      checkVal("seg7", 32'(oSEG7), 32'(eSeg));
      checkVal("digEnN", 32'(oDIG_EN_N), 32'(eEn));
      checkVal("frameDone", 32'(oFRAME_DONE), 32'(eFd));
      checkVal("loadReady", 32'(loadIf.oLOAD_READY), 32'(!mPendFull));
`ifdef SEG7_SCAN_DP_EN
      checkVal("dpN", 32'(oDP_N), 32'(eDp));
`endif
   endtask

   task automatic stepCycle();
      @(posedge iCLK);
      modelEdge();
      #1;
      checkAll();
   endtask

   task automatic idleCycles(input int n);
      repeat (n) stepCycle();
   endtask

   // Offer a value and hold it until accepted (bounded)
   task automatic offer(input logic [15:0] val, input bit blank);
      bit done;
      done = 1'b0;
      loadIf.iLOAD_VALID = 1'b1;
      loadIf.iBCD        = val;
      loadIf.iBLANK_LZ   = blank;
`ifdef SEG7_SCAN_DP_EN
      loadIf.iDP         = 4'($urandom);
`endif
      for (int i = 0; i < 200 && !done; i++) begin
         stepCycle();
         done = mAccepted;
      end
      if (!done) checkVal("offerTimeout", 32'd0, 32'd1);
      loadIf.iLOAD_VALID = 1'b0;
      loadIf.iBCD        = 16'($urandom);
      loadIf.iBLANK_LZ   = 1'($urandom);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog at %0t: got timeout expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      logic [15:0] rv;
      iRST_N             = 1'b0;
      loadIf.iLOAD_VALID = 1'b0;
      loadIf.iBCD        = '0;
      loadIf.iBLANK_LZ   = 1'b0;
`ifdef SEG7_SCAN_DP_EN
      loadIf.iDP         = '0;
`endif
      modelReset();
      #12;
      checkAll();
      iRST_N = 1'b1;

      idleCycles(20);

      offer(16'h1234, 1'b0);
      idleCycles(45);

      offer(16'h0050, 1'b1);
      idleCycles(45);

      offer(16'h0000, 1'b1);
      idleCycles(45);

      offer(16'h5678, 1'b0);
      offer(16'h9999, 1'b0);
      idleCycles(45);

      offer(16'h12A4, 1'b0);
      idleCycles(45);

      // Reset while digit 2 is lit
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         stepCycle();
         found = (eEn == 4'b1011);
      end
      if (!found) checkVal("waitDigit2", 32'd0, 32'd1);
      #2;
      iRST_N = 1'b0;
      #1;
      modelReset();
      checkAll();
      idleCycles(3);
      iRST_N = 1'b1;
      idleCycles(30);

      // Randomized loads, including non-decimal nibbles and blanking
      for (int n = 0; n < 30; n++) begin
         rv = 16'($urandom);
         if ($urandom_range(0, 2) == 0) rv = rv & 16'h00FF;
         if ($urandom_range(0, 3) == 0) rv = 16'h0;
         offer(rv, 1'($urandom));
         idleCycles($urandom_range(0, 30));
      end
      idleCycles(45);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
